// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifft_pkg
// Description : Shared constants for the SDF IFFT datapath. Holds the
//               default sizing, the twiddle-rotation pipeline latency and
//               helpers for the saturation bounds of a signed word.
// Revision    : 1.0 - initial release
// ============================================================================
package ifft_pkg;

    localparam int DEF_NFFT       = 128;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TW_FRAC    = 14;

    // Input-to-output register count of the twiddle rotator.
    localparam int ROT_LATENCY    = 3;

    // Saturation bounds for the default data width.
    localparam longint SAT_MAX = (longint'(1) <<< (DEF_DATA_WIDTH - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (DEF_DATA_WIDTH - 1));

    // Saturation bounds for an arbitrary signed width.
    function automatic longint sat_hi(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifft_twiddle_rotator_cmult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cmult_pipe
// Description : Two-stage pipelined signed complex multiplier p = a * b with
//               round-half-up and reduction to DATA_WIDTH bits.
//               Stage 1 registers the four partial products every cycle.
//               Stage 2 adds/subtracts, rounds, reduces and registers the
//               result only when en is high, so the result holds otherwise.
//               Reduction: TWIDDLE_SAT_EN defined -> clamp to signed range,
//               undefined -> keep the low DATA_WIDTH bits (wrap).
// Ports       : clk, rst_n      clock, async active-low reset
//               en              load enable of the result register
//               a_re, a_im      signed sample
//               b_re, b_im      signed twiddle (TW_FRAC fractional bits)
//               p_re, p_im      registered rotated result
// Revision    : 1.0 - initial release
// ============================================================================
module cmult_pipe
    import ifft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TW_FRAC    = DEF_TW_FRAC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    output logic signed [DATA_WIDTH-1:0] p_re,
    output logic signed [DATA_WIDTH-1:0] p_im
);

    localparam int c_pw = 2 * DATA_WIDTH;
    localparam int c_sw = 2 * DATA_WIDTH + 1;
    localparam logic signed [c_sw-1:0] c_round = c_sw'(1) <<< (TW_FRAC - 1);

`ifdef TWIDDLE_SAT_EN
    localparam logic signed [c_sw-1:0] c_hi = c_sw'(sat_hi(DATA_WIDTH));
    localparam logic signed [c_sw-1:0] c_lo = c_sw'(sat_lo(DATA_WIDTH));
`endif

    logic signed [c_pw-1:0] r_ac;   // a_re * b_re
    logic signed [c_pw-1:0] r_bd;   // a_im * b_im
    logic signed [c_pw-1:0] r_ad;   // a_re * b_im
    logic signed [c_pw-1:0] r_bc;   // a_im * b_re

    logic signed [c_sw-1:0] w_re_sum;
    logic signed [c_sw-1:0] w_im_sum;
    logic signed [c_sw-1:0] w_re_sh;
    logic signed [c_sw-1:0] w_im_sh;

    function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [c_sw-1:0] v);
`ifdef TWIDDLE_SAT_EN
        if (v > c_hi) begin
            return $signed(c_hi[DATA_WIDTH-1:0]);
        end else if (v < c_lo) begin
            return $signed(c_lo[DATA_WIDTH-1:0]);
        end else begin
            return $signed(v[DATA_WIDTH-1:0]);
        end
`else
        return $signed(v[DATA_WIDTH-1:0]);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac <= '0;
            r_bd <= '0;
            r_ad <= '0;
            r_bc <= '0;
        end else begin
            r_ac <= c_pw'(a_re) * c_pw'(b_re);
            r_bd <= c_pw'(a_im) * c_pw'(b_im);
            r_ad <= c_pw'(a_re) * c_pw'(b_im);
            r_bc <= c_pw'(a_im) * c_pw'(b_re);
        end
    end

    // One extra sum bit keeps (-2^(W-1))^2 + (-2^(W-1))^2 exact.
    assign w_re_sum = c_sw'(r_ac) - c_sw'(r_bd);
    assign w_im_sum = c_sw'(r_ad) + c_sw'(r_bc);
    assign w_re_sh  = (w_re_sum + c_round) >>> TW_FRAC;
    assign w_im_sh  = (w_im_sum + c_round) >>> TW_FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en) begin
            p_re <= reduce(w_re_sh);
            p_im <= reduce(w_im_sh);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifft_twiddle_rotator.sv
`default_nettype none
// ============================================================================
// Module      : ifft_twiddle_rotator
// Description : Twiddle-rotation stage following a radix-2 SDF butterfly.
//               Counts samples within the L = NFFT>>STAGE block, drives the
//               combinational twiddle ROM address and multiplies the second
//               half of every block by the returned twiddle. First-half
//               samples bypass the multiplier with matched latency
//               (ROT_LATENCY register stages).
//               Build macro: TWIDDLE_SAT_EN selects saturation instead of
//               wrap-around on the rotated results.
// Ports       : clk, rst_n           clock, async active-low reset
//               clear                sync counter clear (frame realignment);
//                                    the sample on that cycle is dropped
//               in_valid             input strobe
//               in_real, in_imag     signed input sample
//               tw_addr              twiddle ROM address (from counter)
//               tw_real, tw_imag     twiddle from ROM, same cycle as tw_addr
//               out_valid            output strobe
//               out_real, out_imag   output sample
// Revision    : 1.0 - initial release
// ============================================================================
module ifft_twiddle_rotator
    import ifft_pkg::*;
#(
    parameter int NFFT       = DEF_NFFT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STAGE      = 0,
    parameter int TW_FRAC    = DEF_TW_FRAC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  in_real,
    input  logic signed [DATA_WIDTH-1:0]  in_imag,
    output logic [$clog2(NFFT/2)-1:0]     tw_addr,
    input  logic signed [DATA_WIDTH-1:0]  tw_real,
    input  logic signed [DATA_WIDTH-1:0]  tw_imag,
    output logic                          out_valid,
    output logic signed [DATA_WIDTH-1:0]  out_real,
    output logic signed [DATA_WIDTH-1:0]  out_imag
);

    localparam int c_len    = NFFT >> STAGE;
    localparam int c_cnt_w  = (c_len <= 2) ? 1 : $clog2(c_len);
    localparam int c_addr_w = $clog2(NFFT / 2);

    logic [c_cnt_w-1:0]          r_cnt;
    logic                        w_half;
    logic                        w_accept;
    logic [c_addr_w-1:0]         w_addr;

    // P1
    logic                        r_p1_valid;
    logic                        r_p1_bypass;
    logic signed [DATA_WIDTH-1:0] r_p1_re;
    logic signed [DATA_WIDTH-1:0] r_p1_im;
    logic signed [DATA_WIDTH-1:0] r_p1_twr;
    logic signed [DATA_WIDTH-1:0] r_p1_twi;
    // P2 bypass delay line
    logic                        r_p2_valid;
    logic                        r_p2_bypass;
    logic signed [DATA_WIDTH-1:0] r_p2_re;
    logic signed [DATA_WIDTH-1:0] r_p2_im;
    // P3
    logic                        r_p3_valid;
    logic                        r_p3_bypass;
    logic signed [DATA_WIDTH-1:0] r_p3_re;
    logic signed [DATA_WIDTH-1:0] r_p3_im;
    logic signed [DATA_WIDTH-1:0] w_rot_re;
    logic signed [DATA_WIDTH-1:0] w_rot_im;

    assign w_half   = r_cnt[c_cnt_w-1];
    assign w_accept = in_valid & ~clear;

    // Block length is a power of two, so natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    generate
        if (c_cnt_w == 1) begin : g_last_stage
            // L = 2: the rotate half always uses W^0.
            assign w_addr = '0;
        end else begin : g_addr_gen
            logic [c_cnt_w-2:0] w_k;
            assign w_k    = r_cnt[c_cnt_w-2:0];
            assign w_addr = w_half ? (c_addr_w'(w_k) << STAGE) : '0;
        end
    endgenerate

    assign tw_addr = w_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_valid  <= 1'b0;
            r_p1_bypass <= 1'b0;
            r_p1_re     <= '0;
            r_p1_im     <= '0;
            r_p1_twr    <= '0;
            r_p1_twi    <= '0;
            r_p2_valid  <= 1'b0;
            r_p2_bypass <= 1'b0;
            r_p2_re     <= '0;
            r_p2_im     <= '0;
            r_p3_valid  <= 1'b0;
            r_p3_bypass <= 1'b0;
            r_p3_re     <= '0;
            r_p3_im     <= '0;
        end else begin
            r_p1_valid  <= w_accept;
            r_p1_bypass <= ~w_half;
            r_p1_re     <= in_real;
            r_p1_im     <= in_imag;
            r_p1_twr    <= tw_real;
            r_p1_twi    <= tw_imag;
            r_p2_valid  <= r_p1_valid;
            r_p2_bypass <= r_p1_bypass;
            r_p2_re     <= r_p1_re;
            r_p2_im     <= r_p1_im;
            r_p3_valid  <= r_p2_valid;
            // Output-side state only moves on valid so bubbles hold the data.
            if (r_p2_valid) begin
                r_p3_bypass <= r_p2_bypass;
                r_p3_re     <= r_p2_re;
                r_p3_im     <= r_p2_im;
            end
        end
    end

    cmult_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .TW_FRAC    (TW_FRAC)
    ) u_cmult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_p2_valid),
        .a_re  (r_p1_re),
        .a_im  (r_p1_im),
        .b_re  (r_p1_twr),
        .b_im  (r_p1_twi),
        .p_re  (w_rot_re),
        .p_im  (w_rot_im)
    );

    // Both mux legs are registers loaded on the same enable, so the
    // outputs are glitch-free registered values in effect.
    assign out_valid = r_p3_valid;
    assign out_real  = r_p3_bypass ? r_p3_re : w_rot_re;
    assign out_imag  = r_p3_bypass ? r_p3_im : w_rot_im;

endmodule
`default_nettype wire

// File: tb/tb_ifft_twiddle_rotator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifft_twiddle_rotator
// Description : Scoreboard bench for ifft_twiddle_rotator. Two instances:
//               STAGE=0 (L=128) and STAGE=3 (L=16). Stimulus pushes the
//               hand-computed expected output; monitors pop on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifft_twiddle_rotator;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cpx_t;

`ifdef TWIDDLE_SAT_EN
    localparam int c_sat_im = -32768;
`else
    localparam int c_sat_im = 19196;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic               clear0, in_valid0;
    logic signed [15:0] in_real0, in_imag0, tw_real0, tw_imag0;
    logic [5:0]         tw_addr0;
    logic               out_valid0;
    logic signed [15:0] out_real0, out_imag0;

    logic               clear3, in_valid3;
    logic signed [15:0] in_real3, in_imag3, tw_real3, tw_imag3;
    logic [5:0]         tw_addr3;
    logic               out_valid3;
    logic signed [15:0] out_real3, out_imag3;

    cpx_t q0[$];
    cpx_t q3[$];
    logic [2:0] hist0, hist3;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifft_twiddle_rotator #(.NFFT(128), .DATA_WIDTH(16), .STAGE(0), .TW_FRAC(14)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear0), .in_valid(in_valid0),
        .in_real(in_real0), .in_imag(in_imag0), .tw_addr(tw_addr0),
        .tw_real(tw_real0), .tw_imag(tw_imag0), .out_valid(out_valid0),
        .out_real(out_real0), .out_imag(out_imag0)
    );

    ifft_twiddle_rotator #(.NFFT(128), .DATA_WIDTH(16), .STAGE(3), .TW_FRAC(14)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear3), .in_valid(in_valid3),
        .in_real(in_real3), .in_imag(in_imag3), .tw_addr(tw_addr3),
        .tw_real(tw_real3), .tw_imag(tw_imag3), .out_valid(out_valid3),
        .out_real(out_real3), .out_imag(out_imag3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected out_valid: accepted strobes delayed by three register stages.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0 <= 3'b000;
            hist3 <= 3'b000;
        end else begin
            hist0 <= {hist0[1:0], in_valid0 & ~clear0};
            hist3 <= {hist3[1:0], in_valid3 & ~clear3};
        end
    end

    always @(negedge clk) begin
        cpx_t e;
        if (rst_n) begin
            chk("out_valid0", longint'(out_valid0), longint'(hist0[2]));
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_out0", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("out_real0", out_real0, e.re);
                    chk("out_imag0", out_imag0, e.im);
                end
            end
            chk("out_valid3", longint'(out_valid3), longint'(hist3[2]));
            if (out_valid3) begin
                if (q3.size() == 0) begin
                    chk("unexpected_out3", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("out_real3", out_real3, e.re);
                    chk("out_imag3", out_imag3, e.im);
                end
            end
        end
    end

    task automatic drive0(input logic v, input logic clr, input int re, input int im,
                          input int twr, input int twi, input int exp_addr,
                          input int ere, input int eim);
        cpx_t e;
        in_valid0 = v;
        clear0    = clr;
        in_real0  = 16'(re);
        in_imag0  = 16'(im);
        tw_real0  = 16'(twr);
        tw_imag0  = 16'(twi);
        chk("tw_addr0", tw_addr0, exp_addr);
        if (v && !clr) begin
            e.re = 16'(ere);
            e.im = 16'(eim);
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        clear0    = 1'b0;
    endtask

    task automatic drive3(input logic v, input int re, input int im,
                          input int twr, input int twi, input int exp_addr,
                          input int ere, input int eim);
        cpx_t e;
        in_valid3 = v;
        in_real3  = 16'(re);
        in_imag3  = 16'(im);
        tw_real3  = 16'(twr);
        tw_imag3  = 16'(twi);
        chk("tw_addr3", tw_addr3, exp_addr);
        if (v) begin
            e.re = 16'(ere);
            e.im = 16'(eim);
            q3.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
    endtask

    initial begin
        int re, im, m;
        logic half;
        rst_n = 1'b0;
        clear0 = 1'b0; in_valid0 = 1'b0; in_real0 = '0; in_imag0 = '0; tw_real0 = '0; tw_imag0 = '0;
        clear3 = 1'b0; in_valid3 = 1'b0; in_real3 = '0; in_imag3 = '0; tw_real3 = '0; tw_imag3 = '0;

        #3;
        chk("reset_out_valid0", longint'(out_valid0), 0);
        chk("reset_out_real0", out_real0, 0);
        chk("reset_out_imag0", out_imag0, 0);
        chk("reset_tw_addr0", tw_addr0, 0);
        chk("reset_tw_addr3", tw_addr3, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full STAGE=0 block with twiddle j: rotate half gives (-im, re).
        for (int i = 0; i < 128; i++) begin
            re = i;
            im = 2 * i + 1;
            if (i == 10 || i == 96) begin
                re = 1000;
                im = 0;
            end
            if (i < 64) drive0(1'b1, 1'b0, re, im, 0, 16384, 0, re, im);
            else        drive0(1'b1, 1'b0, re, im, 0, 16384, i - 64, -im, re);
        end

        // Counter wrapped: a further first half of bypass samples.
        for (int i = 0; i < 64; i++) begin
            drive0(1'b1, 1'b0, i, -i, 0, 16384, 0, i, -i);
        end

        // cnt 64: extreme input against (11585,11585).
        drive0(1'b1, 1'b0, -32768, -32768, 11585, 11585, 0, 0, c_sat_im);

        // Valid toggling: cnt advances on valid cycles only.
        drive0(1'b1, 1'b0, 5, 7, 0, 16384, 1, -7, 5);
        drive0(1'b0, 1'b0, 0, 0, 0, 0, 2, 0, 0);
        drive0(1'b1, 1'b0, -3, 4, 0, 16384, 2, -4, -3);
        drive0(1'b0, 1'b0, 0, 0, 0, 0, 3, 0, 0);

        // Other twiddles: W^0, -1, and a rounding case (1.5 -> 2).
        drive0(1'b1, 1'b0, 100, 200, 16384, 0, 3, 100, 200);
        drive0(1'b1, 1'b0, -7, 9, -16384, 0, 4, 7, -9);
        drive0(1'b1, 1'b0, 3, 0, 8192, 8192, 5, 2, 2);

        // clear with in_valid at cnt 70: sample dropped, next one bypasses.
        drive0(1'b1, 1'b1, 77, 77, 0, 16384, 6, 0, 0);
        drive0(1'b1, 1'b0, 123, -45, 0, 16384, 0, 123, -45);
        for (int i = 0; i < 5; i++) drive0(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain0", q0.size(), 0);

        // STAGE=3 instance, L=16.
        for (int i = 0; i < 25; i++) begin
            m    = i % 16;
            half = (m >= 8);
            if (half) drive3(1'b1, i + 1, 3 * i, 0, 16384, (m - 8) << 3, -3 * i, i + 1);
            else      drive3(1'b1, i + 1, 3 * i, 0, 16384, 0, i + 1, 3 * i);
        end
        chk("tw_addr3_cnt9", tw_addr3, 8);

        // Asynchronous reset mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid0", longint'(out_valid0), 0);
        chk("midrst_out_real0", out_real0, 0);
        chk("midrst_out_imag0", out_imag0, 0);
        chk("midrst_out_valid3", longint'(out_valid3), 0);
        chk("midrst_out_real3", out_real3, 0);
        chk("midrst_out_imag3", out_imag3, 0);
        chk("midrst_tw_addr3", tw_addr3, 0);
        chk("midrst_tw_addr0", tw_addr0, 0);
        q0.delete();
        q3.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive3(1'b1, 50, 60, 0, 16384, 0, 50, 60);
        drive0(1'b1, 1'b0, 11, 22, 0, 16384, 0, 11, 22);
        for (int i = 0; i < 5; i++) drive0(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain0_final", q0.size(), 0);
        chk("drain3_final", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
